// File: rtl/regarb_pkg.sv
// Shared types and widths for the register-file write arbiter.
package regarb_pkg;

  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned AGE_W            = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester, register-file write port and status bundle of the write arbiter.
interface regfile_write_arbiter_if;
  import regarb_pkg::*;

  logic                  core_req;
  logic [REG_ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0]     core_data;
  logic                  core_gnt;
  logic                  aux_req;
  logic [REG_ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0]     aux_data;
  logic                  aux_gnt;
  logic                  rf_rw;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0]     rf_data;
  logic                  busy;

  modport master (
    output core_req, core_addr, core_data, aux_req, aux_addr, aux_data,
    input  core_gnt, aux_gnt, rf_rw, rf_addr, rf_data, busy
  );

  modport slave (
    input  core_req, core_addr, core_data, aux_req, aux_addr, aux_data,
    output core_gnt, aux_gnt, rf_rw, rf_addr, rf_data, busy
  );

endinterface

// File: rtl/regarb_aging_ctr.sv
// Aux starvation counter; only instantiated when REGARB_AGING_EN is defined.
module regarb_aging_ctr
  import regarb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic aux_req,
  input  logic aux_gnt,
  output logic starved_c
);

  logic [AGE_W-1:0] cnt;

  // Count denied aux cycles, saturating at LIMIT; any grant or idle clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!aux_req || aux_gnt) begin
      cnt <= '0;
    end else if (cnt != AGE_W'(LIMIT)) begin
      cnt <= cnt + AGE_W'(1);
    end
  end

  assign starved_c = (cnt == AGE_W'(LIMIT));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter with post-reset clear sequence.
// Define REGARB_AGING_EN to let a starved aux requester override core priority.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned NUM_REGS     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS + 1);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic                  rf_rw;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0]     rf_data;
  logic                  core_gnt_c;
  logic                  aux_gnt_c;
  logic                  aux_first_c;
  wr_req_t               sel_c;

  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15 || NUM_REGS == 0 || NUM_REGS > 32) begin : g_bad_param
    $error("regfile_write_arbiter: STARVE_LIMIT or NUM_REGS out of range");
  end

`ifdef REGARB_AGING_EN
  regarb_aging_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_aging (
    .clk       (clk),
    .rst_n     (rst_n),
    .aux_req   (bus.aux_req),
    .aux_gnt   (aux_gnt_c),
    .starved_c (aux_first_c)
  );
`else
  assign aux_first_c = 1'b0;
`endif

  // Grant selection: nothing during CLEAR, core first unless aux is starved
  always_comb begin
    core_gnt_c = 1'b0;
    aux_gnt_c  = 1'b0;
    sel_c      = '{addr: bus.core_addr, data: bus.core_data};
    if (state == RUN) begin
      if (bus.aux_req && (aux_first_c || !bus.core_req)) begin
        aux_gnt_c = 1'b1;
        sel_c     = '{addr: bus.aux_addr, data: bus.aux_data};
      end else if (bus.core_req) begin
        core_gnt_c = 1'b1;
      end
    end
  end

  // FSM and registered write port; the clear stays in CLEAR one extra cycle so
  // the last clear write is still flagged busy while it is on the port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      idx     <= '0;
      rf_rw   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else if (state == CLEAR) begin
      if (idx == IDX_W'(NUM_REGS)) begin
        state <= RUN;
        rf_rw <= 1'b0;
      end else begin
        rf_rw   <= 1'b1;
        rf_addr <= REG_ADDR_W'(idx);
        rf_data <= '0;
        idx     <= idx + IDX_W'(1);
      end
    end else begin
      if (core_gnt_c || aux_gnt_c) begin
        rf_rw   <= (sel_c.addr != '0);
        rf_addr <= sel_c.addr;
        rf_data <= sel_c.data;
      end else begin
        rf_rw <= 1'b0;
      end
    end
  end

  assign bus.core_gnt = core_gnt_c;
  assign bus.aux_gnt  = aux_gnt_c;
  assign bus.rf_rw    = rf_rw;
  assign bus.rf_addr  = rf_addr;
  assign bus.rf_data  = rf_data;
  assign bus.busy     = (state == CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: cycle model plus directed and random stimulus.
module tb_regfile_write_arbiter;
  import regarb_pkg::*;

  localparam int unsigned NREGS = 32;
  localparam int unsigned LIMIT = 4;
`ifdef REGARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .NUM_REGS     (NREGS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t = rising edges since reset release; the first NREGS edges clear,
  // grants start once t exceeds NREGS, transfers land on the port one edge later.
  int          t;
  int          starve;
  logic        m_rw;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] dut_rf [NREGS];
  logic [31:0] mdl_rf [NREGS];

  initial begin
    t = 0; starve = 0; m_rw = 1'b0; m_addr = '0; m_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      dut_rf[i] = 32'hDEAD_BEEF;
      mdl_rf[i] = 32'h0;
    end
  end

  always @(negedge clk) begin : compare
    bit          run, aux_win, core_win;
    logic [4:0]  a;
    logic [31:0] d;
    if (!rst_n) begin
      chk("rst_busy", 64'(bus.busy), 64'(1));
      chk("rst_rf_rw", 64'(bus.rf_rw), 64'(0));
      chk("rst_rf_addr", 64'(bus.rf_addr), 64'(0));
      chk("rst_rf_data", 64'(bus.rf_data), 64'(0));
      chk("rst_gnts", 64'({bus.core_gnt, bus.aux_gnt}), 64'(0));
      t = 0; starve = 0; m_rw = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      run      = (t > int'(NREGS));
      aux_win  = run && bus.aux_req && (!bus.core_req || (AGING && starve == int'(LIMIT)));
      core_win = run && bus.core_req && !aux_win;
      chk("busy", 64'(bus.busy), 64'(t <= int'(NREGS)));
      chk("core_gnt", 64'(bus.core_gnt), 64'(core_win));
      chk("aux_gnt", 64'(bus.aux_gnt), 64'(aux_win));
      chk("rf_rw", 64'(bus.rf_rw), 64'(m_rw));
      chk("rf_addr", 64'(bus.rf_addr), 64'(m_addr));
      chk("rf_data", 64'(bus.rf_data), 64'(m_data));
      if (bus.rf_rw === 1'b1) dut_rf[bus.rf_addr] = bus.rf_data;
      if (t < int'(NREGS)) begin
        m_rw = 1'b1; m_addr = 5'(t); m_data = '0;
        mdl_rf[t] = 32'h0;
      end else if (core_win || aux_win) begin
        a = aux_win ? bus.aux_addr : bus.core_addr;
        d = aux_win ? bus.aux_data : bus.core_data;
        m_rw = (a != 5'd0); m_addr = a; m_data = d;
        if (a != 5'd0) mdl_rf[a] = d;
      end else begin
        m_rw = 1'b0;
      end
      if (bus.aux_req && !aux_win) starve = (starve < int'(LIMIT)) ? starve + 1 : starve;
      else starve = 0;
      if (t < 1000000) t++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  nclr, core_n, aux_first;
    bit  found, c_seen, a_seen;
    rst_n = 1'b0;
    bus.core_req = 1'b0; bus.core_addr = '0; bus.core_data = '0;
    bus.aux_req  = 1'b0; bus.aux_addr  = '0; bus.aux_data  = '0;
    repeat (3) @(posedge clk);
    #1 chk("lit_rst_busy", 64'(bus.busy), 64'(1));
    chk("lit_rst_rw", 64'(bus.rf_rw), 64'(0));
    rst_n = 1'b1;

    // Core pulse during clear must never be granted
    @(posedge clk); #1;
    bus.core_req = 1'b1; bus.core_addr = 5'd21; bus.core_data = 32'h1234_5678;
    #1 chk("lit_clear_core_gnt", 64'(bus.core_gnt), 64'(0));
    @(posedge clk); #1 bus.core_req = 1'b0;

    // Reset while the clear is at index 17
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.rf_rw === 1'b1 && bus.rf_addr == 5'd17) found = 1'b1;
    end
    chk("lit_idx17_reached", 64'(found), 64'(1));
    rst_n = 1'b0;
    #1 chk("lit_midrst_rw", 64'(bus.rf_rw), 64'(0));
    chk("lit_midrst_addr", 64'(bus.rf_addr), 64'(0));
    chk("lit_midrst_busy", 64'(bus.busy), 64'(1));
    @(posedge clk); #1 rst_n = 1'b1;

    // Full clear restarts from address 0
    nclr = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b1) break;
      chk("lit_clear_addr", 64'(bus.rf_addr), 64'(nclr));
      nclr++;
    end
    chk("lit_clear_len", 64'(nclr), 64'(32));
    chk("lit_run_busy", 64'(bus.busy), 64'(0));
    chk("lit_run_rw", 64'(bus.rf_rw), 64'(0));

    // Single core write
    bus.core_req = 1'b1; bus.core_addr = 5'd9; bus.core_data = 32'h18;
    #1 chk("lit_core_gnt", 64'(bus.core_gnt), 64'(1));
    @(posedge clk); #1 bus.core_req = 1'b0;
    chk("lit_core_rw", 64'(bus.rf_rw), 64'(1));
    chk("lit_core_addr", 64'(bus.rf_addr), 64'(9));
    chk("lit_core_data", 64'(bus.rf_data), 64'(32'h18));

    // Aux write to register 0 is accepted but suppressed
    bus.aux_req = 1'b1; bus.aux_addr = 5'd0; bus.aux_data = 32'hFFFF_FFFF;
    #1 chk("lit_aux0_gnt", 64'(bus.aux_gnt), 64'(1));
    @(posedge clk); #1 bus.aux_req = 1'b0;
    chk("lit_aux0_rw", 64'(bus.rf_rw), 64'(0));

    // Both requesting continuously
    bus.core_req = 1'b1; bus.core_addr = 5'd5; bus.core_data = 32'hAAAA_0005;
    bus.aux_req  = 1'b1; bus.aux_addr  = 5'd6; bus.aux_data  = 32'hBBBB_0006;
    core_n = 0; aux_first = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (bus.aux_gnt === 1'b1 && aux_first == 0) aux_first = i;
      if (bus.core_gnt === 1'b1) core_n++;
      @(posedge clk); #1;
      if (aux_first == i) begin
        bus.aux_req = 1'b0;
        chk("lit_aging_aux_data", 64'(bus.rf_data), 64'(32'hBBBB_0006));
      end
    end
    if (AGING) begin
      chk("lit_aging_aux_cycle", 64'(aux_first), 64'(5));
      chk("lit_aging_core_n", 64'(core_n), 64'(7));
    end else begin
      chk("lit_strict_aux_never", 64'(aux_first), 64'(0));
      chk("lit_strict_core_n", 64'(core_n), 64'(8));
    end
    bus.core_req = 1'b0; bus.aux_req = 1'b0;

    // Random traffic: hold until granted, occasionally drop
    c_seen = 1'b0; a_seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!bus.core_req || c_seen || $urandom_range(0, 15) == 0) begin
        bus.core_req  = ($urandom_range(0, 2) != 0);
        bus.core_addr = 5'($urandom);
        bus.core_data = $urandom;
      end
      if (!bus.aux_req || a_seen || $urandom_range(0, 15) == 0) begin
        bus.aux_req  = ($urandom_range(0, 1) != 0);
        bus.aux_addr = 5'($urandom);
        bus.aux_data = $urandom;
      end
      #3;
      c_seen = bus.core_gnt; a_seen = bus.aux_gnt;
      @(posedge clk); #1;
    end
    bus.core_req = 1'b0; bus.aux_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < int'(NREGS); i++)
      chk($sformatf("rf_entry[%0d]", i), 64'(dut_rf[i]), 64'(mdl_rf[i]));
    chk("lit_rf0_zero", 64'(dut_rf[0]), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
